// File: rtl/serial_addsub.sv
// Digit-serial add/subtract unit: DIGIT bits per clock, NDIG cycles per operation,
// start/busy/done handshake with registered SUM, CO, OV and ZERO results.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             CO,
    output logic             OV,
    output logic             ZERO
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   dsum;
    logic [DIGIT-1:0] d;
    logic             c;
    logic             c_msb;
    logic [WIDTH-1:0] sum_full;

    assign dsum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign d    = dsum[DIGIT-1:0];
    assign c    = dsum[DIGIT];
    // Carry into the top bit of this digit, recovered from its sum bit and operand bits.
    assign c_msb = d[DIGIT-1] ^ a_sh[DIGIT-1] ^ b_sh[DIGIT-1];

    // a_sh doubles as the partial-sum register: result digits enter at the top
    // while operand digits leave at the bottom, so after NDIG steps it holds the sum.
    generate
        if (DIGIT == WIDTH) begin : g_single
            assign sum_full = d;
        end else begin : g_multi
            assign sum_full = {d, a_sh[WIDTH-1:DIGIT]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            SUM   <= '0;
            CO    <= 1'b0;
            OV    <= 1'b0;
            ZERO  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B ^ {WIDTH{SUB}};
                        carry <= SUB;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= sum_full;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= c;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        SUM   <= sum_full;
                        CO    <= c;
                        OV    <= c_msb ^ c;
                        ZERO  <= (sum_full == '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and randomised bench for serial_addsub across four WIDTH/DIGIT configurations
// sharing one stimulus bus; results checked against hand values and a behavioural model.
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub_i = 1'b0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;

    logic        busy8, done8, co8, ov8, zero8;
    logic [7:0]  sum8;
    logic        busy16w, done16w, co16w, ov16w, zero16w;
    logic [15:0] sum16w;
    logic        busy16n, done16n, co16n, ov16n, zero16n;
    logic [15:0] sum16n;
    logic        busy32, done32, co32, ov32, zero32;
    logic [31:0] sum32;

    logic [3:0]  done_all, co_all, ov_all, zero_all;
    logic [31:0] sum_all [4];

    int checks = 0;
    int errors = 0;
    int wid [4] = '{8, 16, 16, 32};
    int lat_exp [4] = '{4, 1, 4, 32};

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .DIGIT(2)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .SUB(sub_i), .A(a_i[7:0]), .B(b_i[7:0]),
        .busy(busy8), .done(done8), .SUM(sum8), .CO(co8), .OV(ov8), .ZERO(zero8));
    serial_addsub #(.WIDTH(16), .DIGIT(16)) u16w (
        .clk(clk), .rst_n(rst_n), .start(start), .SUB(sub_i), .A(a_i[15:0]), .B(b_i[15:0]),
        .busy(busy16w), .done(done16w), .SUM(sum16w), .CO(co16w), .OV(ov16w), .ZERO(zero16w));
    serial_addsub #(.WIDTH(16), .DIGIT(4)) u16n (
        .clk(clk), .rst_n(rst_n), .start(start), .SUB(sub_i), .A(a_i[15:0]), .B(b_i[15:0]),
        .busy(busy16n), .done(done16n), .SUM(sum16n), .CO(co16n), .OV(ov16n), .ZERO(zero16n));
    serial_addsub #(.WIDTH(32), .DIGIT(1)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .SUB(sub_i), .A(a_i), .B(b_i),
        .busy(busy32), .done(done32), .SUM(sum32), .CO(co32), .OV(ov32), .ZERO(zero32));

    assign done_all = {done32, done16n, done16w, done8};
    assign co_all   = {co32, co16n, co16w, co8};
    assign ov_all   = {ov32, ov16n, ov16w, ov8};
    assign zero_all = {zero32, zero16n, zero16w, zero8};
    assign sum_all[0] = {24'b0, sum8};
    assign sum_all[1] = {16'b0, sum16w};
    assign sum_all[2] = {16'b0, sum16n};
    assign sum_all[3] = sum32;

    // Behavioural reference: returns {zero, ov, co, sum}.
    function automatic logic [34:0] model(int w, logic sub, logic [31:0] a, logic [31:0] b);
        logic [63:0] mask, am, bm, full, s;
        logic        co, ov, an, bn, sn;
        mask = (64'h1 << w) - 64'h1;
        am   = {32'b0, a} & mask;
        bm   = (sub ? ~{32'b0, b} : {32'b0, b}) & mask;
        full = am + bm + {63'b0, sub};
        s    = full & mask;
        co   = full[w];
        an   = am[w-1];
        bn   = b[w-1];
        sn   = s[w-1];
        ov   = sub ? ((an != bn) && (sn != an)) : ((an == bn) && (sn != an));
        return {(s == 64'b0), ov, co, s[31:0]};
    endfunction

    task automatic launch(logic sub, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        sub_i = sub;
        a_i   = a;
        b_i   = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run8(string name, logic sub, logic [7:0] a, logic [7:0] b,
                        logic [7:0] es, logic eco, logic eov, logic ez);
        int lat;
        lat = 0;
        launch(sub, {24'b0, a}, {24'b0, b});
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL %s busy_after_start: got %b want 1", name, busy8); end
        for (int e = 1; e <= 10 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) lat = e;
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL %s latency: got %0d want 4", name, lat); end
        checks++;
        if (sum8 !== es) begin errors++; $display("FAIL %s SUM: got %h want %h", name, sum8, es); end
        checks++;
        if (co8 !== eco) begin errors++; $display("FAIL %s CO: got %b want %b", name, co8, eco); end
        checks++;
        if (ov8 !== eov) begin errors++; $display("FAIL %s OV: got %b want %b", name, ov8, eov); end
        checks++;
        if (zero8 !== ez) begin errors++; $display("FAIL %s ZERO: got %b want %b", name, zero8, ez); end
        checks++;
        if (busy8 !== 1'b0) begin errors++; $display("FAIL %s busy_at_done: got %b want 0", name, busy8); end
        @(posedge clk);
        #1;
        checks++;
        if (done8 !== 1'b0) begin errors++; $display("FAIL %s done_width: got %b want 0", name, done8); end
        $display("op %s: SUM=%h CO=%b OV=%b ZERO=%b latency=%0d", name, sum8, co8, ov8, zero8, lat);
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, sum8, co8, ov8, zero8} !== 13'b0) begin
            errors++;
            $display("FAIL reset_outputs_8: got busy=%b done=%b SUM=%h CO=%b OV=%b ZERO=%b want all 0",
                     busy8, done8, sum8, co8, ov8, zero8);
        end
        checks++;
        if ({busy32, done32, sum32, co32, ov32, zero32} !== 37'b0) begin
            errors++;
            $display("FAIL reset_outputs_32: got busy=%b SUM=%h ZERO=%b want all 0", busy32, sum32, zero32);
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: outputs cleared, released");
    endtask

    task automatic test_add;
        run8("add_00_01", 1'b0, 8'h00, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        run8("add_07_08", 1'b0, 8'h07, 8'h08, 8'h0F, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        run8("add_FF_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run8("add_7F_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_sub;
        run8("sub_03_04", 1'b1, 8'h03, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b0);
        run8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run8("sub_05_05", 1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_busy;
        int nd, first;
        nd = 0;
        first = 0;
        launch(1'b0, 32'h10, 32'h10);
        for (int e = 1; e <= 12; e++) begin
            if (e == 2) begin
                @(negedge clk);
                start = 1'b1;
                a_i = 32'h01;
                b_i = 32'h01;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done8 === 1'b1) begin
                nd++;
                if (first == 0) first = e;
            end
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL ignore_busy done_count: got %0d want 1", nd); end
        checks++;
        if (first != 4) begin errors++; $display("FAIL ignore_busy latency: got %0d want 4", first); end
        checks++;
        if (sum8 !== 8'h20) begin errors++; $display("FAIL ignore_busy SUM: got %h want 20", sum8); end
        $display("op ignore_busy: SUM=%h dones=%0d", sum8, nd);
    endtask

    task automatic test_back_to_back;
        int lat;
        lat = 0;
        launch(1'b0, 32'h10, 32'h10);
        for (int e = 1; e <= 10 && lat == 0; e++) begin
            @(posedge clk);
            #1;
            if (done8 === 1'b1) lat = e;
        end
        checks++;
        if (lat != 4) begin errors++; $display("FAIL b2b first_latency: got %0d want 4", lat); end
        // Still inside the done cycle: the unit is idle and must accept this request.
        start = 1'b1;
        a_i = 32'h02;
        b_i = 32'h03;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b accepted busy: got %b want 1", busy8); end
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (sum8 !== 8'h20 || done8 !== 1'b0) begin
                errors++;
                $display("FAIL b2b hold edge %0d: got SUM=%h done=%b want SUM=20 done=0", e, sum8, done8);
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (done8 !== 1'b1 || sum8 !== 8'h05) begin
            errors++;
            $display("FAIL b2b second result: got done=%b SUM=%h want done=1 SUM=05", done8, sum8);
        end
        $display("op back_to_back: SUM=%h done=%b", sum8, done8);
    endtask

    task automatic test_reset_midop;
        launch(1'b0, 32'h55, 32'h22);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, co8, ov8, zero8} !== 13'b0) begin
            errors++;
            $display("FAIL midop_reset outputs: got busy=%b done=%b SUM=%h CO=%b OV=%b ZERO=%b want all 0",
                     busy8, done8, sum8, co8, ov8, zero8);
        end
        for (int e = 0; e < 3; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== 1'b0 || busy8 !== 1'b0) begin
                errors++;
                $display("FAIL midop_reset hold: got done=%b busy=%b want 0 0", done8, busy8);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("op midop_reset: aborted");
        run8("after_reset_01_01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sweep_op(logic sub, logic [31:0] a, logic [31:0] b);
        int lat_seen [4];
        int ndone [4];
        logic [34:0] ex;
        for (int i = 0; i < 4; i++) begin lat_seen[i] = 0; ndone[i] = 0; end
        launch(sub, a, b);
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (done_all[i] === 1'b1) begin
                    ndone[i]++;
                    if (lat_seen[i] == 0) lat_seen[i] = e;
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            ex = model(wid[i], sub, a, b);
            checks++;
            if (lat_seen[i] != lat_exp[i] || ndone[i] != 1) begin
                errors++;
                $display("FAIL sweep w%0d latency/dones: got %0d/%0d want %0d/1", wid[i], lat_seen[i], ndone[i], lat_exp[i]);
            end
            checks++;
            if (sum_all[i] !== ex[31:0]) begin
                errors++;
                $display("FAIL sweep w%0d SUM sub=%b a=%h b=%h: got %h want %h", wid[i], sub, a, b, sum_all[i], ex[31:0]);
            end
            checks++;
            if (co_all[i] !== ex[32]) begin
                errors++;
                $display("FAIL sweep w%0d CO sub=%b a=%h b=%h: got %b want %b", wid[i], sub, a, b, co_all[i], ex[32]);
            end
            checks++;
            if (ov_all[i] !== ex[33]) begin
                errors++;
                $display("FAIL sweep w%0d OV sub=%b a=%h b=%h: got %b want %b", wid[i], sub, a, b, ov_all[i], ex[33]);
            end
            checks++;
            if (zero_all[i] !== ex[34]) begin
                errors++;
                $display("FAIL sweep w%0d ZERO sub=%b a=%h b=%h: got %b want %b", wid[i], sub, a, b, zero_all[i], ex[34]);
            end
        end
    endtask

    task automatic test_wide_edge;
        repeat (40) @(posedge clk);
        sweep_op(1'b0, 32'h0000_FFFF, 32'h0000_0001);
        checks++;
        if (sum16w !== 16'h0000 || co16w !== 1'b1) begin
            errors++;
            $display("FAIL wide_16x16 FFFF+0001: got SUM=%h CO=%b want 0000 1", sum16w, co16w);
        end
        $display("op wide_16x16: SUM=%h CO=%b ZERO=%b", sum16w, co16w, zero16w);
    endtask

    task automatic test_sweep;
        logic [31:0] a, b;
        logic sub;
        int err0;
        for (int n = 0; n < 1000; n++) begin
            a = $urandom;
            b = (n % 8 == 0) ? a : $urandom;
            sub = 1'($urandom_range(0, 1));
            err0 = errors;
            sweep_op(sub, a, b);
            $display("sweep %0d: sub=%b a=%h b=%h sum32=%h new_errors=%0d", n, sub, a, b, sum32, errors - err0);
        end
    endtask

    initial begin
        test_reset;
        test_add;
        test_wrap;
        test_sub;
        test_ignore_busy;
        test_back_to_back;
        test_reset_midop;
        test_wide_edge;
        test_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised, multi-cycle, digit-serial add/subtract unit for the 8-bit MIPS datapath and its wider successors. It generalises the combinational 8-bit adder to any `WIDTH`, and adds a subtract mode, signed-overflow and zero flags, and a start/busy/done handshake. It processes `DIGIT` bits per clock and trades latency for a narrow carry chain. It sits beside the ALU and is launched by the control unit.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `DIGIT`, default 2: bits added per cycle. `WIDTH` must be an integer multiple of `DIGIT`. `NDIG = WIDTH/DIGIT`.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: request; sampled only when idle (`busy`=0).
- `SUB`  in  1: 0 selects A+B, 1 selects A−B. Sampled with `start`.
- `A`  in  WIDTH: operand A, sampled with `start`.
- `B`  in  WIDTH: operand B, sampled with `start`.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse; results have just been updated.
- `SUM`  out  WIDTH: registered result.
- `CO`  out  1: carry out of the MSB. In subtract mode it is the inverted borrow, so 1 means A ≥ B unsigned.
- `OV`  out  1: two's-complement overflow.
- `ZERO`  out  1: `SUM` == 0.

## Operation
- **FSM states.** IDLE and RUN.
- **IDLE with `start`=1.**
  - Latch `A` into shift register `a_sh`.
  - Latch `B` XOR {WIDTH{SUB}} into shift register `b_sh`.
  - Set `carry` = SUB and digit counter `cnt` = 0.
  - Set `busy` = 1 and go to RUN.
  - `start`=0 in IDLE keeps the unit in IDLE.
- **Each RUN cycle:**
  - Compute `{c, d} = a_sh[DIGIT-1:0] + b_sh[DIGIT-1:0] + carry`, a (DIGIT+1)-bit add.
  - Shift `d` into the top of the partial-sum register from the left (right shift by `DIGIT`).
  - Shift `a_sh` and `b_sh` right by `DIGIT`.
  - Set `carry` = `c` and `cnt` = `cnt`+1.
- **Last digit (`cnt` == NDIG−1):**
  - Write the full sum to `SUM`.
  - Set `CO` = `c`.
  - Set `OV` = (carry into bit WIDTH−1) XOR `c`, where the carry into the MSB is taken inside the final digit add.
  - Set `ZERO` = (final sum == 0).
  - Pulse `done` = 1, set `busy` = 0, return to IDLE.
- **Result holding.** `SUM`, `CO`, `OV` and `ZERO` are registers. They change only at completion and hold through the next operation until that operation's `done`.
- **`start` while busy.** A `start` while `busy`=1 is ignored; it is not queued. `A`, `B` and `SUB` may change freely while busy.
- **`cnt` width.** `cnt` is $clog2(NDIG) bits, minimum 1. It wraps to 0 on completion.
- **`DIGIT` == `WIDTH`.** NDIG=1: a single RUN cycle.

## Timing
- **Reset.** While `rst_n`=0: state IDLE, and `busy`, `done`, `SUM`, `CO`, `OV`, `ZERO` are all 0. `ZERO` reads 0 in reset even though `SUM` is 0. Internal registers are also cleared.
- **Reset mid-operation.** Aborts immediately. No `done` is produced and outputs return to their reset values. After `rst_n` rises, the first rising edge may accept `start`.
- **Latency.** With `start` sampled at edge k:
  - `busy` goes high after edge k.
  - RUN occupies edges k+1 … k+NDIG.
  - `done`=1 and the new results are visible after edge k+NDIG. `busy` falls at the same edge.
  - `done` is low again after edge k+NDIG+1.
- **Throughput.** `start` sampled in the cycle `done`=1 is accepted, because the unit is IDLE then. This gives back-to-back operations every NDIG+1 cycles.
- **Flag validity.** `done` and the flags share one edge; no output is combinational from inputs.

## Test plan
All scenarios use WIDTH=8 and DIGIT=2, so NDIG=4, unless stated otherwise.
- **Add 0x00+0x01.** Pulse `start`, `SUB`=0 → `done` 4 edges after the sampling edge; `SUM`=0x01, `CO`=0, `OV`=0, `ZERO`=0. Then add 0x07+0x08 → `SUM`=0x0F.
- **Wrap-around.** 0xFF+0x01 → `SUM`=0x00, `CO`=1, `ZERO`=1, `OV`=0. Then 0x7F+0x01 → `SUM`=0x80, `OV`=1, `CO`=0.
- **Subtract.**
  - 0x03−0x04 → `SUM`=0xFF, `CO`=0, `OV`=0.
  - 0x80−0x01 → `SUM`=0x7F, `OV`=1, `CO`=1.
  - 0x05−0x05 → `SUM`=0x00, `ZERO`=1, `CO`=1.
- **Handshake.**
  - `start` with 0x10+0x10, then `start` again 2 cycles later with 0x01+0x01 → the second request is ignored: `SUM`=0x20, a single `done`.
  - `start` asserted in the `done` cycle with 0x02+0x03 → accepted; previous `SUM` held until `SUM`=0x05 and `done` 4 edges later.
- **Reset mid-op.** Start 0x55+0x22, then assert `rst_n`=0 after 2 RUN edges → `busy`=0, `SUM`=0x00, no `done`. After release, a new 0x01+0x01 completes normally with `SUM`=0x02.
- **Parameter sweep.**
  - WIDTH=16, DIGIT=16 → 0xFFFF+0x0001 gives `done` 1 edge after start, `SUM`=0x0000, `CO`=1.
  - WIDTH=16, DIGIT=4 → `done` after 4 edges.
  - WIDTH=32, DIGIT=1 → `done` after 32 edges.
  - For each configuration, 1000 random operations compared against a reference model, including `SUB`.
